// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: states, display sources,
// operator codes and phase LED patterns.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_ENT_A = 3'd0,
    ST_ENT_B = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHOW  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] DISP_A   = 2'b00;
  localparam logic [1:0] DISP_B   = 2'b01;
  localparam logic [1:0] DISP_RES = 2'b10;
  localparam logic [1:0] DISP_ERR = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // WAIT keeps the ENT_B phase LED; only BUSY distinguishes it.
  localparam logic [3:0] LED_ENT_A = 4'b0001;
  localparam logic [3:0] LED_ENT_B = 4'b0010;
  localparam logic [3:0] LED_WAIT  = 4'b0010;
  localparam logic [3:0] LED_SHOW  = 4'b0100;
  localparam logic [3:0] LED_ERR   = 4'b1100;

endpackage

// File: rtl/calc_sequencer_if.sv
// Key, operator handshake and display signals of the calculator sequencer.
// slave is the sequencer side, master is the board/datapath side.
interface calc_sequencer_if;
  logic       KEY1_N;
  logic       KEY2_N;
  logic [1:0] OP_SEL;
  logic       OP_DONE;
  logic       OP_ERR;
  logic       LOAD_A;
  logic       LOAD_B;
  logic       OP_START;
  logic [1:0] OP_CODE;
  logic [1:0] DISP_SEL;
  logic [3:0] LEDG;
  logic       BUSY;

  modport master (
    output KEY1_N, KEY2_N, OP_SEL, OP_DONE, OP_ERR,
    input  LOAD_A, LOAD_B, OP_START, OP_CODE, DISP_SEL, LEDG, BUSY
  );

  modport slave (
    input  KEY1_N, KEY2_N, OP_SEL, OP_DONE, OP_ERR,
    output LOAD_A, LOAD_B, OP_START, OP_CODE, DISP_SEL, LEDG, BUSY
  );
endinterface

// File: rtl/key_debounce.sv
// Raw active-low key -> synchronized, debounced level -> one-cycle press pulse.
// The accepted level moves only after DB_CNT consecutive cycles at the new
// value; any return to the accepted level restarts the count.
module key_debounce #(
  parameter int DB_CNT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchronize, count stable cycles, and pulse on the accepted 1->0 change.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      level_d <= level;
      press   <= level_d & ~level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Operand entry / operator sequencing FSM for the four-function calculator.
// state  | meaning
// ENT_A  | entering operand A; STORE loads A, NEXT moves on
// ENT_B  | entering operand B; STORE loads B, NEXT starts the operator
// WAIT   | operator running; keys discarded, done/error/timeout awaited
// SHOW   | result displayed; NEXT returns to ENT_A
// ERR    | fault displayed; NEXT returns to ENT_A
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DB_CNT  = 500000,
  parameter int TIMEOUT = 64
) (
  input logic             CLOCK_50,
  input logic             RST,
  calc_sequencer_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Transition is taken on the edge where the count would reach TIMEOUT.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          next_ev;
  logic          store_ev;
  logic          load_a_q;
  logic          load_b_q;
  logic          op_start_q;
  logic [1:0]    op_code_q;
  logic [1:0]    disp_q;
  logic [3:0]    ledg_q;
  logic          busy_q;

  key_debounce #(.DB_CNT(DB_CNT)) u_next_key (
    .clk   (CLOCK_50),
    .rst   (RST),
    .key_n (bus.KEY1_N),
    .press (next_ev)
  );

  key_debounce #(.DB_CNT(DB_CNT)) u_store_key (
    .clk   (CLOCK_50),
    .rst   (RST),
    .key_n (bus.KEY2_N),
    .press (store_ev)
  );

  // State sequencing with registered pulses, LEDs, display select and timeout.
  // STORE is tested before NEXT so a simultaneous NEXT is dropped.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state      <= ST_ENT_A;
      tmo_cnt    <= '0;
      load_a_q   <= 1'b0;
      load_b_q   <= 1'b0;
      op_start_q <= 1'b0;
      op_code_q  <= OP_ADD;
      disp_q     <= DISP_A;
      ledg_q     <= LED_ENT_A;
      busy_q     <= 1'b0;
    end else begin
      load_a_q   <= 1'b0;
      load_b_q   <= 1'b0;
      op_start_q <= 1'b0;
      case (state)
        ST_ENT_A: begin
          if (store_ev) begin
            load_a_q <= 1'b1;
          end else if (next_ev) begin
            state  <= ST_ENT_B;
            ledg_q <= LED_ENT_B;
            disp_q <= DISP_B;
          end
        end
        ST_ENT_B: begin
          if (store_ev) begin
            load_b_q <= 1'b1;
          end else if (next_ev) begin
            state      <= ST_WAIT;
            op_start_q <= 1'b1;
            op_code_q  <= bus.OP_SEL;
            busy_q     <= 1'b1;
            tmo_cnt    <= '0;
            ledg_q     <= LED_WAIT;
            disp_q     <= DISP_B;
          end
        end
        ST_WAIT: begin
          if (bus.OP_DONE) begin
            busy_q <= 1'b0;
            if (bus.OP_ERR) begin
              state  <= ST_ERR;
              ledg_q <= LED_ERR;
              disp_q <= DISP_ERR;
            end else begin
              state  <= ST_SHOW;
              ledg_q <= LED_SHOW;
              disp_q <= DISP_RES;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            busy_q <= 1'b0;
            state  <= ST_ERR;
            ledg_q <= LED_ERR;
            disp_q <= DISP_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_SHOW, ST_ERR: begin
          if (next_ev) begin
            state  <= ST_ENT_A;
            ledg_q <= LED_ENT_A;
            disp_q <= DISP_A;
          end
        end
        default: begin
          state  <= ST_ENT_A;
          ledg_q <= LED_ENT_A;
          disp_q <= DISP_A;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.LOAD_A   = load_a_q;
  assign bus.LOAD_B   = load_b_q;
  assign bus.OP_START = op_start_q;
  assign bus.OP_CODE  = op_code_q;
  assign bus.DISP_SEL = disp_q;
  assign bus.LEDG     = ledg_q;
  assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with DB_CNT=4, TIMEOUT=8.
// A key driven just after edge k yields its output pulse right after edge k+8.
module tb_calc_sequencer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   la_cnt;
  int   lb_cnt;
  int   st_cnt;

  calc_sequencer_if bus ();

  calc_sequencer #(.DB_CNT(4), .TIMEOUT(8)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.LOAD_A)   la_cnt++;
    if (bus.LOAD_B)   lb_cnt++;
    if (bus.OP_START) st_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // key 1 = NEXT, key 2 = STORE; hold long enough for press and release.
  task automatic press(input int key);
    if (key == 1) bus.KEY1_N = 1'b0;
    else          bus.KEY2_N = 1'b0;
    repeat (12) step();
    bus.KEY1_N = 1'b1;
    bus.KEY2_N = 1'b1;
    repeat (12) step();
  endtask

  // From ENT_B: press NEXT and return right after the OP_START edge.
  task automatic start_op(input logic [1:0] sel);
    bus.OP_SEL = sel;
    bus.KEY1_N = 1'b0;
    repeat (8) step();
    bus.KEY1_N = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0;
    la_cnt = 0; lb_cnt = 0; st_cnt = 0;
    bus.KEY1_N = 1'b1; bus.KEY2_N = 1'b1;
    bus.OP_SEL = 2'b00; bus.OP_DONE = 1'b0; bus.OP_ERR = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ledg", 32'(bus.LEDG), 32'h1);
    chk("rst_disp", 32'(bus.DISP_SEL), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_code", 32'(bus.OP_CODE), 32'h0);
    chk("rst_pulses", 32'({bus.LOAD_A, bus.LOAD_B, bus.OP_START}), 32'h0);
    rst = 1'b0;
    step();

    // Full sequence with multiply.
    press(2);
    chk("t1_la", 32'(la_cnt), 32'd1);
    chk("t1_enta_ledg", 32'(bus.LEDG), 32'h1);
    press(1);
    chk("t1_entb_ledg", 32'(bus.LEDG), 32'h2);
    chk("t1_entb_disp", 32'(bus.DISP_SEL), 32'h1);
    press(2);
    chk("t1_lb", 32'(lb_cnt), 32'd1);
    start_op(2'b10);
    chk("t1_start", 32'(bus.OP_START), 32'h1);
    chk("t1_busy", 32'(bus.BUSY), 32'h1);
    chk("t1_code", 32'(bus.OP_CODE), 32'h2);
    chk("t1_wait_ledg", 32'(bus.LEDG), 32'h2);
    bus.OP_SEL = 2'b01;
    step();
    chk("t1_start_1cyc", 32'(bus.OP_START), 32'h0);
    step();
    chk("t1_busy_hold", 32'(bus.BUSY), 32'h1);
    bus.OP_DONE = 1'b1;
    step();
    bus.OP_DONE = 1'b0;
    chk("t1_show_ledg", 32'(bus.LEDG), 32'h4);
    chk("t1_show_disp", 32'(bus.DISP_SEL), 32'h2);
    chk("t1_show_busy", 32'(bus.BUSY), 32'h0);
    chk("t1_code_kept", 32'(bus.OP_CODE), 32'h2);
    chk("t1_st", 32'(st_cnt), 32'd1);
    repeat (12) step();
    press(2);
    chk("t1_show_store_ign", 32'(bus.LEDG), 32'h4);
    chk("t1_show_no_la", 32'(la_cnt), 32'd1);
    press(1);
    chk("t1_back_enta", 32'(bus.LEDG), 32'h1);

    // Bouncing STORE then a clean hold.
    bus.KEY2_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.KEY2_N = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) step();
    end
    chk("t2_bounce_no_la", 32'(la_cnt), 32'd1);
    bus.KEY2_N = 1'b0;
    repeat (7) step();
    chk("t2_la_early", 32'(bus.LOAD_A), 32'h0);
    step();
    chk("t2_la_on_time", 32'(bus.LOAD_A), 32'h1);
    step();
    chk("t2_la_one_cyc", 32'(bus.LOAD_A), 32'h0);
    step();
    bus.KEY2_N = 1'b1;
    repeat (12) step();
    chk("t2_la_count", 32'(la_cnt), 32'd2);

    // Operator fault.
    press(1);
    start_op(2'b11);
    step();
    bus.OP_DONE = 1'b1; bus.OP_ERR = 1'b1;
    step();
    bus.OP_DONE = 1'b0; bus.OP_ERR = 1'b0;
    chk("t3_err_ledg", 32'(bus.LEDG), 32'hC);
    chk("t3_err_disp", 32'(bus.DISP_SEL), 32'h3);
    chk("t3_err_busy", 32'(bus.BUSY), 32'h0);
    repeat (10) step();
    press(1);
    chk("t3_enta_ledg", 32'(bus.LEDG), 32'h1);
    chk("t3_enta_disp", 32'(bus.DISP_SEL), 32'h0);

    // Timeout, then a late done.
    press(1);
    start_op(2'b00);
    chk("t4_code", 32'(bus.OP_CODE), 32'h0);
    repeat (7) step();
    chk("t4_still_wait", 32'(bus.LEDG), 32'h2);
    chk("t4_still_busy", 32'(bus.BUSY), 32'h1);
    step();
    chk("t4_tmo_ledg", 32'(bus.LEDG), 32'hC);
    chk("t4_tmo_busy", 32'(bus.BUSY), 32'h0);
    bus.OP_DONE = 1'b1;
    step();
    bus.OP_DONE = 1'b0;
    step();
    chk("t4_late_done_ign", 32'(bus.LEDG), 32'hC);
    repeat (10) step();
    press(1);
    chk("t4_enta", 32'(bus.LEDG), 32'h1);

    // Simultaneous STORE + NEXT in ENT_A.
    bus.KEY1_N = 1'b0; bus.KEY2_N = 1'b0;
    repeat (8) step();
    chk("t5_la_pulse", 32'(bus.LOAD_A), 32'h1);
    chk("t5_stay_enta", 32'(bus.LEDG), 32'h1);
    bus.KEY1_N = 1'b1; bus.KEY2_N = 1'b1;
    repeat (12) step();
    chk("t5_enta_after", 32'(bus.LEDG), 32'h1);
    chk("t5_la_count", 32'(la_cnt), 32'd3);

    // STORE event arriving while in WAIT.
    press(1);
    bus.OP_SEL = 2'b01;
    bus.KEY1_N = 1'b0;
    repeat (3) step();
    bus.KEY2_N = 1'b0;
    repeat (5) step();
    chk("t5_start", 32'(bus.OP_START), 32'h1);
    bus.KEY1_N = 1'b1;
    repeat (4) step();
    chk("t5_wait_ledg", 32'(bus.LEDG), 32'h2);
    chk("t5_wait_busy", 32'(bus.BUSY), 32'h1);
    chk("t5_wait_no_lb", 32'(lb_cnt), 32'd1);
    bus.OP_DONE = 1'b1;
    step();
    bus.OP_DONE = 1'b0;
    bus.KEY2_N = 1'b1;
    chk("t5_show", 32'(bus.LEDG), 32'h4);
    repeat (12) step();
    chk("t5_no_la", 32'(la_cnt), 32'd3);
    press(1);
    chk("t5_enta", 32'(bus.LEDG), 32'h1);

    // Reset in WAIT, then a stray done.
    press(1);
    start_op(2'b10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_ledg", 32'(bus.LEDG), 32'h1);
    chk("t6_rst_disp", 32'(bus.DISP_SEL), 32'h0);
    chk("t6_rst_busy", 32'(bus.BUSY), 32'h0);
    chk("t6_rst_code", 32'(bus.OP_CODE), 32'h0);
    bus.OP_DONE = 1'b1;
    step();
    bus.OP_DONE = 1'b0;
    chk("t6_done_ign_ledg", 32'(bus.LEDG), 32'h1);
    chk("t6_done_ign_disp", 32'(bus.DISP_SEL), 32'h0);
    step();
    chk("t6_st_count", 32'(st_cnt), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Synchronous control FSM for the four-function calculator datapath. It debounces the raw NEXT and STORE keys and sequences operand entry: it pulses load enables into the operand A/B registers, then issues a one-shot start to a multi-cycle operator and waits for its done/error handshake. It also drives the phase LEDs and the display-source select. It replaces the key-clocked state logic, so the whole calculator runs in the `CLOCK_50` domain.

## Interface
Parameters:
- `DB_CNT`, default 500000: number of consecutive stable cycles required to accept a key level (10 ms at 50 MHz).
- `TIMEOUT`, default 64: maximum number of cycles spent in WAIT before an error is flagged.

Ports (one clock; reset is synchronous and active-high):
- `CLOCK_50`  in  1  system clock.
- `RST`  in  1  synchronous, active-high reset.
- `KEY1_N`  in  1  raw NEXT key, active-low, asynchronous.
- `KEY2_N`  in  1  raw STORE key, active-low, asynchronous.
- `OP_SEL`  in  2  operation select from the switches (00 add, 01 sub, 10 mul, 11 div).
- `OP_DONE`  in  1  operator completion, one-cycle pulse.
- `OP_ERR`  in  1  operator fault (div-by-0/overflow); valid only with `OP_DONE`.
- `LOAD_A`  out  1  one-cycle load enable, operand A register.
- `LOAD_B`  out  1  one-cycle load enable, operand B register.
- `OP_START`  out  1  one-cycle operator start.
- `OP_CODE`  out  2  `OP_SEL` latched at start; held stable until the next start.
- `DISP_SEL`  out  2  display source: 00 A, 01 B, 10 result, 11 error pattern.
- `LEDG`  out  4  [2:0] one-hot phase, [3] error.
- `BUSY`  out  1  high while the operator is running.

## Operation
- Key path:
  - 2-flop synchronizer, then a debounce counter.
  - The accepted level changes only after `DB_CNT` consecutive cycles at the new value; any bounce reloads the counter.
  - A press event is a single-cycle pulse on the accepted 1→0 transition. A held key produces exactly one event.
- States and transitions:
  - ENT_A (LEDG 0001, DISP 00): STORE → `LOAD_A`. NEXT → ENT_B.
  - ENT_B (LEDG 0010, DISP 01): STORE → `LOAD_B`. NEXT → `OP_START`, latch `OP_CODE`, go to WAIT.
  - WAIT (LEDG 0010, DISP 01, `BUSY`=1): all key events are discarded.
    - `OP_DONE` with `OP_ERR`=0 → SHOW.
    - `OP_DONE` with `OP_ERR`=1 → ERR.
    - Timeout counter reaches `TIMEOUT` → ERR.
  - SHOW (LEDG 0100, DISP 10): NEXT → ENT_A. STORE is ignored.
  - ERR (LEDG 1100, DISP 11): NEXT → ENT_A. STORE is ignored.
- Event conflicts and stray handshakes:
  - STORE and NEXT events in the same cycle: STORE is acted on and NEXT is dropped.
  - `OP_DONE` and timeout in the same cycle: done wins.
  - `OP_DONE` outside WAIT is ignored.
- Timeout counter: cleared on entry to WAIT; width is `$clog2(TIMEOUT+1)`.
- Reset (applies mid-operation too): state ENT_A, all counters 0, accepted key levels 1.
- Output reset values: `LOAD_A`=`LOAD_B`=`OP_START`=0, `OP_CODE`=00, `DISP_SEL`=00, `LEDG`=0001, `BUSY`=0.
- A pulse due in the same cycle as `RST` is suppressed.

## Timing
- All outputs are registered.
- Raw key edge to press event: 2 sync cycles + `DB_CNT` cycles + 1.
- Press event at edge N → `LOAD_x`/`OP_START` high for exactly the cycle after edge N+1. The state/LEDG/`DISP_SEL` update is registered at that same edge.
- `BUSY` rises together with `OP_START` and falls on the edge that registers `OP_DONE` or the timeout.
- `OP_DONE` is allowed one cycle after `OP_START` at the earliest.
- `OP_CODE` is sampled from `OP_SEL` in the event cycle. Changing `OP_SEL` in other cycles has no effect.

## Structure
- Shared package `calc_pkg`:
  - state encodings (ENT_A, ENT_B, WAIT, SHOW, ERR);
  - `DISP_SEL` codes;
  - op codes;
  - LEDG phase constants.
- Sub-module `key_debounce` (synchronizer + counter + falling-edge pulse, parameter `DB_CNT`), instantiated twice.
- FSM, timeout counter and output registers sit in the top level.

## Test plan
Benches run with `DB_CNT`=4 and `TIMEOUT`=8.
1. Reset, then a full sequence: STORE, NEXT, STORE, NEXT with `OP_SEL`=10 → one `LOAD_A`, one `LOAD_B`, one `OP_START`; `OP_CODE`=10; `BUSY`=1. `OP_DONE` 3 cycles later → SHOW, LEDG 0100, DISP 10, `BUSY`=0.
2. Bounce: `KEY2_N` toggles every 2 cycles for 20 cycles, then held low for 10 cycles → exactly one `LOAD_A`, with the timing above.
3. Divide by zero: `OP_DONE`=1 with `OP_ERR`=1 in WAIT → ERR, LEDG 1100, DISP 11. NEXT → ENT_A, LEDG 0001.
4. No `OP_DONE` → ERR 8 cycles after `OP_START`. A late `OP_DONE` arriving in ERR is ignored.
5. STORE and NEXT pressed in the same cycle in ENT_A → `LOAD_A` pulse; state stays ENT_A. Key presses during WAIT → no outputs pulse and the state is unchanged.
6. `RST` asserted in WAIT one cycle before `OP_DONE` → all outputs take their reset values on the next edge. The following `OP_DONE` is ignored and the state stays ENT_A.
